// File: rtl/i2c_passthru_pkg.sv
// Shared defaults, counter widths and state type for the I2C pass-through idle/stuck detector.
package i2c_passthru_pkg;

  // Bus-free time after STOP, in fast reference ticks (5 us at 4 MHz).
  localparam int unsigned FRefTLowDef          = 20;
  // Both-lines-high time before idle, in slow reference ticks.
  localparam int unsigned FRefSlowTHiMaxDef    = 2;
  // Line-low time before stuck, in slow reference ticks (~32 ms at 4 kHz).
  localparam int unsigned FRefSlowTStuckMaxDef = 127;

  localparam int unsigned WidthFRefTLowDef     = 5;
  localparam int unsigned WidthFRefSlowDef     = 7;

  // Idle tracking: busy, counting bus-free time after a STOP, or idle.
  typedef enum logic [1:0] {
    StBusy,
    StBusFree,
    StIdle
  } idle_st_e;

endpackage

// File: rtl/i2c_passthru_edge_det.sv
// Sample register plus rising/falling pulse for one asynchronous input.
// With I2C_PASSTHRU_IN_SYNC_EN defined a 2-flop synchronizer precedes the sample register's
// history stage; otherwise the input is captured by a single sample register.
module i2c_passthru_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic prev_o,
  output logic rise_o,
  output logic fall_o
);

  logic sample_d;
  logic sample_q;
  logic prev_q;

`ifdef I2C_PASSTHRU_IN_SYNC_EN
  logic meta_q;

  // First synchronizer stage; the sample register acts as the second.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
    end else begin
      meta_q <= d_i;
    end
  end

  assign sample_d = meta_q;
`else
  assign sample_d = d_i;
`endif

  // Current sample and one cycle of history for edge detection.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sample_q <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      sample_q <= sample_d;
      prev_q   <= sample_q;
    end
  end

  assign level_o = sample_q;
  assign prev_o  = prev_q;
  assign rise_o  = sample_q & ~prev_q;
  assign fall_o  = ~sample_q & prev_q;

endmodule

// File: rtl/i2c_passthru_idle_stuck_det.sv
// I2C bus idle and stuck-line detector.
// o_idle: both lines high long enough (slow ticks), or bus-free time elapsed after a STOP.
// o_stuck: either line held low for the stuck time. Optional input synchronizers are enabled by
// defining I2C_PASSTHRU_IN_SYNC_EN (see i2c_passthru_edge_det).
module i2c_passthru_idle_stuck_det
  import i2c_passthru_pkg::*;
#(
  parameter int unsigned F_REF_T_LOW            = FRefTLowDef,
  parameter int unsigned F_REF_SLOW_T_HI_MAX    = FRefSlowTHiMaxDef,
  parameter int unsigned F_REF_SLOW_T_STUCK_MAX = FRefSlowTStuckMaxDef,
  parameter int unsigned WIDTH_F_REF_T_LOW      = WidthFRefTLowDef,
  parameter int unsigned WIDTH_F_REF_SLOW       = WidthFRefSlowDef
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_f_ref,
  input  logic i_f_ref_slow,
  input  logic i_sda,
  input  logic i_scl,
  output logic o_idle,
  output logic o_stuck
);

  localparam logic [WIDTH_F_REF_T_LOW-1:0] TLow     = WIDTH_F_REF_T_LOW'(F_REF_T_LOW);
  localparam logic [WIDTH_F_REF_T_LOW-1:0] FastOne  = WIDTH_F_REF_T_LOW'(1);
  localparam logic [WIDTH_F_REF_SLOW-1:0]  HiMax    = WIDTH_F_REF_SLOW'(F_REF_SLOW_T_HI_MAX);
  localparam logic [WIDTH_F_REF_SLOW-1:0]  StuckMax = WIDTH_F_REF_SLOW'(F_REF_SLOW_T_STUCK_MAX);
  localparam logic [WIDTH_F_REF_SLOW-1:0]  SlowOne  = WIDTH_F_REF_SLOW'(1);

  logic sda_lvl, sda_prev, sda_rise, sda_fall;
  logic scl_lvl, scl_prev, scl_rise, scl_fall;
  logic fast_lvl, fast_prev, fast_tick, fast_fall;
  logic slow_lvl, slow_prev, slow_tick, slow_fall;

  i2c_passthru_edge_det u_sda_det (
    .clk_i   (i_clk),
    .rst_ni  (i_rstn),
    .d_i     (i_sda),
    .level_o (sda_lvl),
    .prev_o  (sda_prev),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  i2c_passthru_edge_det u_scl_det (
    .clk_i   (i_clk),
    .rst_ni  (i_rstn),
    .d_i     (i_scl),
    .level_o (scl_lvl),
    .prev_o  (scl_prev),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_passthru_edge_det u_fast_det (
    .clk_i   (i_clk),
    .rst_ni  (i_rstn),
    .d_i     (i_f_ref),
    .level_o (fast_lvl),
    .prev_o  (fast_prev),
    .rise_o  (fast_tick),
    .fall_o  (fast_fall)
  );

  i2c_passthru_edge_det u_slow_det (
    .clk_i   (i_clk),
    .rst_ni  (i_rstn),
    .d_i     (i_f_ref_slow),
    .level_o (slow_lvl),
    .prev_o  (slow_prev),
    .rise_o  (slow_tick),
    .fall_o  (slow_fall)
  );

  // Only the rising ticks and line levels matter here.
  logic unused_edges;
  assign unused_edges = ^{sda_prev, sda_fall, scl_rise, scl_fall,
                          fast_lvl, fast_prev, fast_fall, slow_lvl, slow_prev, slow_fall};

  logic both_hi;
  logic stop_det;
  assign both_hi  = sda_lvl & scl_lvl;
  // SCL must be high on both samples so an SDA rise during SCL low is ignored.
  assign stop_det = sda_rise & scl_lvl & scl_prev;

  logic [WIDTH_F_REF_SLOW-1:0]  hi_cnt_d, hi_cnt_q;
  logic [WIDTH_F_REF_SLOW-1:0]  scl_low_d, scl_low_q;
  logic [WIDTH_F_REF_SLOW-1:0]  sda_low_d, sda_low_q;
  logic [WIDTH_F_REF_T_LOW-1:0] bf_cnt_d, bf_cnt_q;
  idle_st_e                     state_d, state_q;
  logic                         idle_d, idle_q;
  logic                         stuck_d, stuck_q;

  // Saturating timers; a low line always clears, even on a tick cycle.
  always_comb begin
    hi_cnt_d  = hi_cnt_q;
    scl_low_d = scl_low_q;
    sda_low_d = sda_low_q;
    bf_cnt_d  = '0;

    if (!both_hi) begin
      hi_cnt_d = '0;
    end else if (slow_tick && (hi_cnt_q < HiMax)) begin
      hi_cnt_d = hi_cnt_q + SlowOne;
    end

    if (scl_lvl) begin
      scl_low_d = '0;
    end else if (slow_tick && (scl_low_q < StuckMax)) begin
      scl_low_d = scl_low_q + SlowOne;
    end

    if (sda_lvl) begin
      sda_low_d = '0;
    end else if (slow_tick && (sda_low_q < StuckMax)) begin
      sda_low_d = sda_low_q + SlowOne;
    end

    // Bus-free timer only runs in StBusFree and restarts whenever that state is left.
    if (both_hi && (state_q == StBusFree)) begin
      bf_cnt_d = bf_cnt_q;
      if (fast_tick && (bf_cnt_q < TLow)) begin
        bf_cnt_d = bf_cnt_q + FastOne;
      end
    end

    stuck_d = (scl_low_d == StuckMax) || (sda_low_d == StuckMax);
  end

  // Idle FSM next state; outputs are decoded from next values so they register together.
  always_comb begin
    state_d = state_q;

    if (!both_hi) begin
      state_d = StBusy;
    end else if (hi_cnt_d >= HiMax) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StBusy: begin
          if (stop_det) begin
            state_d = StBusFree;
          end
        end
        StBusFree: begin
          if (bf_cnt_d >= TLow) begin
            state_d = StIdle;
          end
        end
        StIdle: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StBusy;
        end
      endcase
    end

    idle_d = (state_d == StIdle) && !stuck_d;
  end

  // State, counters and registered outputs; synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      hi_cnt_q  <= '0;
      scl_low_q <= '0;
      sda_low_q <= '0;
      bf_cnt_q  <= '0;
      state_q   <= StBusy;
      idle_q    <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      hi_cnt_q  <= hi_cnt_d;
      scl_low_q <= scl_low_d;
      sda_low_q <= sda_low_d;
      bf_cnt_q  <= bf_cnt_d;
      state_q   <= state_d;
      idle_q    <= idle_d;
      stuck_q   <= stuck_d;
    end
  end

  assign o_idle  = idle_q;
  assign o_stuck = stuck_q;

endmodule

// File: tb/tb_i2c_passthru_idle_stuck_det.sv
// Directed bench for i2c_passthru_idle_stuck_det at default parameters.
// Time is scaled: clock period 10, fast reference period 4 clocks, slow reference period
// 128 clocks. So idle via the hi counter needs >= ~128 clocks, bus-free after STOP ~80 clocks,
// and stuck 127 slow ticks (~16130..16260 clocks).
module tb_i2c_passthru_idle_stuck_det;

  logic clk        = 1'b0;
  logic rstn       = 1'b0;
  logic f_ref      = 1'b0;
  logic f_ref_slow = 1'b0;
  logic sda        = 1'b1;
  logic scl        = 1'b1;
  logic idle;
  logic stuck;

  int checks = 0;
  int errors = 0;

  i2c_passthru_idle_stuck_det dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_f_ref      (f_ref),
    .i_f_ref_slow (f_ref_slow),
    .i_sda        (sda),
    .i_scl        (scl),
    .o_idle       (idle),
    .o_stuck      (stuck)
  );

  always #5 clk = ~clk;

  // Reference clocks toggle away from the posedges (which fall at 5 mod 10).
  initial begin
    #2;
    forever #20 f_ref = ~f_ref;
  end

  initial begin
    #3;
    forever #640 f_ref_slow = ~f_ref_slow;
  end

  // Advance n posedges, then settle 1 time unit past the edge for driving/sampling.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    sda  = 1'b1;
    scl  = 1'b1;
    step(3);
    checks++;
    if (idle !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: o_idle=%b, required 0", idle);
    end
    checks++;
    if (stuck !== 1'b0) begin
      errors++;
      $display("FAIL reset_stuck: o_stuck=%b, required 0", stuck);
    end
  endtask

  // Lines high after reset: idle only via the hi counter (two slow ticks).
  task automatic test_idle_hi();
    bit bad;
    int n;
    rstn = 1'b1;
    bad  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (!bad && (idle !== 1'b0 || stuck !== 1'b0)) begin
        bad = 1'b1;
        $display("FAIL idle_hi_early: cycle %0d o_idle=%b o_stuck=%b, required 0 0",
                 i, idle, stuck);
      end
    end
    checks++;
    if (bad) errors++;

    n = 0;
    while (idle !== 1'b1 && n < 300) begin
      step(1);
      n++;
    end
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("FAIL idle_hi_set: o_idle=%b after %0d cycles, required 1", idle, n);
    end

    bad = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (!bad && (idle !== 1'b1 || stuck !== 1'b0)) begin
        bad = 1'b1;
        $display("FAIL idle_hi_stable: cycle %0d o_idle=%b o_stuck=%b, required 1 0",
                 i, idle, stuck);
      end
    end
    checks++;
    if (bad) errors++;
  endtask

  // Lines low drop idle fast; SDA rising while SCL low is not a STOP.
  task automatic test_low_clears();
    bit bad;
    int n;
    sda = 1'b0;
    scl = 1'b0;
    n = 0;
    while (idle !== 1'b0 && n < 4) begin
      step(1);
      n++;
    end
    checks++;
    if (idle !== 1'b0 || n > 3) begin
      errors++;
      $display("FAIL low_clears_idle: o_idle=%b after %0d cycles, required 0 within 3", idle, n);
    end

    sda = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (!bad && (idle !== 1'b0 || stuck !== 1'b0)) begin
        bad = 1'b1;
        $display("FAIL sda_rise_scl_low: cycle %0d o_idle=%b o_stuck=%b, required 0 0",
                 i, idle, stuck);
      end
    end
    checks++;
    if (bad) errors++;
  endtask

  // STOP then bus-free count: idle near 80 clocks, well before the hi path could fire.
  task automatic test_stop();
    bit bad;
    int n;
    sda = 1'b0;
    step(1);
    scl = 1'b1;
    step(2);
    sda = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (!bad && idle !== 1'b0) begin
        bad = 1'b1;
        $display("FAIL stop_early_idle: cycle %0d o_idle=%b, required 0", i, idle);
      end
    end
    checks++;
    if (bad) errors++;

    n = 60;
    while (idle !== 1'b1 && n < 100) begin
      step(1);
      n++;
    end
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("FAIL stop_idle: o_idle=%b after %0d cycles, required 1", idle, n);
    end
    checks++;
    if (stuck !== 1'b0) begin
      errors++;
      $display("FAIL stop_stuck: o_stuck=%b, required 0", stuck);
    end
  endtask

  // Bus-free count aborted by SCL low must not resume; only the hi path then gives idle.
  task automatic test_stop_abort();
    bit bad;
    int n;
    sda = 1'b0;
    step(2);
    sda = 1'b1;
    step(40);
    scl = 1'b0;
    step(3);
    scl = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (!bad && idle !== 1'b0) begin
        bad = 1'b1;
        $display("FAIL abort_no_idle: cycle %0d o_idle=%b, required 0", i, idle);
      end
    end
    checks++;
    if (bad) errors++;

    n = 0;
    while (idle !== 1'b1 && n < 300) begin
      step(1);
      n++;
    end
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("FAIL abort_hi_idle: o_idle=%b after %0d cycles, required 1", idle, n);
    end
  endtask

  // One line held low from reset; stuck after ~127 slow ticks, then release or reset.
  task automatic test_stuck(input bit hold_scl, input bit end_with_reset);
    bit bad;
    int n;
    rstn = 1'b0;
    step(2);
    scl  = hold_scl ? 1'b0 : 1'b1;
    sda  = hold_scl ? 1'b1 : 1'b0;
    rstn = 1'b1;

    bad = 1'b0;
    for (int i = 0; i < 16000; i++) begin
      step(1);
      if (!bad && (idle !== 1'b0 || stuck !== 1'b0)) begin
        bad = 1'b1;
        $display("FAIL stuck_early(scl=%0d): cycle %0d o_idle=%b o_stuck=%b, required 0 0",
                 hold_scl, i, idle, stuck);
      end
    end
    checks++;
    if (bad) errors++;

    n = 16000;
    while (stuck !== 1'b1 && n < 16600) begin
      step(1);
      n++;
    end
    checks++;
    if (stuck !== 1'b1) begin
      errors++;
      $display("FAIL stuck_set(scl=%0d): o_stuck=%b after %0d cycles, required 1",
               hold_scl, stuck, n);
    end

    bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      if (!bad && (idle !== 1'b0 || stuck !== 1'b1)) begin
        bad = 1'b1;
        $display("FAIL stuck_hold(scl=%0d): cycle %0d o_idle=%b o_stuck=%b, required 0 1",
                 hold_scl, i, idle, stuck);
      end
    end
    checks++;
    if (bad) errors++;

    if (end_with_reset) begin
      rstn = 1'b0;
      step(1);
      checks++;
      if (stuck !== 1'b0 || idle !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset: o_idle=%b o_stuck=%b, required 0 0", idle, stuck);
      end
      rstn = 1'b1;
      bad  = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        step(1);
        if (!bad && stuck !== 1'b0) begin
          bad = 1'b1;
          $display("FAIL mid_reset_restart: cycle %0d o_stuck=%b, required 0", i, stuck);
        end
      end
      checks++;
      if (bad) errors++;
    end

    scl = 1'b1;
    sda = 1'b1;
    step(2);
    checks++;
    if (stuck !== 1'b0) begin
      errors++;
      $display("FAIL stuck_release(scl=%0d): o_stuck=%b, required 0", hold_scl, stuck);
    end

    n = 0;
    while (idle !== 1'b1 && n < 300) begin
      step(1);
      n++;
    end
    checks++;
    if (idle !== 1'b1 || stuck !== 1'b0) begin
      errors++;
      $display("FAIL release_idle(scl=%0d): o_idle=%b o_stuck=%b after %0d, required 1 0",
               hold_scl, idle, stuck, n);
    end
  endtask

  initial begin
    test_reset();
    test_idle_hi();
    test_low_clears();
    test_stop();
    test_stop_abort();
    test_stuck(1'b1, 1'b0);
    test_stuck(1'b0, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_passthru_idle_stuck_det.md
I2C_PASSTHRU_IDLE_STUCK_DET -- requirements
Module: i2c_passthru_idle_stuck_det

Interface
REQ-001 SHALL have parameter F_REF_T_LOW, default 20, bus-free time after STOP, in i_f_ref rising edges (5 us at 4 MHz).
REQ-002 SHALL have parameter F_REF_SLOW_T_HI_MAX, default 2, both-lines-high time before idle, in i_f_ref_slow rising edges.
REQ-003 SHALL have parameter F_REF_SLOW_T_STUCK_MAX, default 127, line-low time before stuck, in i_f_ref_slow rising edges (~32 ms at 4 kHz).
REQ-004 SHALL have parameter WIDTH_F_REF_T_LOW, default 5, bus-free counter width.
REQ-005 SHALL have parameter WIDTH_F_REF_SLOW, default 7, slow counter width.
REQ-006 SHALL have port i_clk, input, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port i_rstn, input, 1; reset is synchronous and active-low.
REQ-008 SHALL have port i_f_ref, input, 1, free-running fast reference (~4 MHz), i_clk-sampled.
REQ-009 SHALL have port i_f_ref_slow, input, 1, free-running slow reference (~4 kHz), i_clk-sampled.
REQ-010 SHALL have ports i_sda and i_scl, input, 1 each, I2C line levels.
REQ-011 SHALL have ports o_idle and o_stuck, output, 1 each, registered.

Function
REQ-012 SHALL detect reference ticks as 0->1 transitions of i_f_ref / i_f_ref_slow between consecutive i_clk samples; one tick per edge.
REQ-013 SHALL run hi counter: clear when either line low; +1 per slow tick while both high; saturate; o_idle set on reaching F_REF_SLOW_T_HI_MAX (250-500 us at defaults).
REQ-014 SHALL detect STOP: sampled sda 0->1 while scl sampled 1 on both samples; SDA rising while SCL low is not STOP.
REQ-015 SHALL after STOP run bus-free counter: +1 per fast tick while both high; o_idle set on reaching F_REF_T_LOW; abort/clear if either line low.
REQ-016 SHALL clear o_idle on the clock after either line samples low; pin-to-o_idle fall latency <=3 i_clk cycles.
REQ-017 SHALL run separate scl_low and sda_low counters: clear while own line high; +1 per slow tick while low; saturate at F_REF_SLOW_T_STUCK_MAX.
REQ-018 SHALL assert o_stuck while either low counter is saturated; deassert on the clock after the saturated line samples high.
REQ-019 SHALL force o_idle=0 whenever o_stuck=1; o_stuck never asserts while both lines high.
REQ-020 SHALL treat simultaneous tick and line-low as line-low (clear wins).

Reset
REQ-021 SHALL on i_rstn=0 at a rising i_clk clear all counters, edge/sample history, o_idle=0, o_stuck=0.
REQ-022 SHALL, reset mid-operation, restart all timing from zero; lines high after reset give idle only via hi counter.

Configuration
REQ-023 SHALL with I2C_PASSTHRU_IN_SYNC_EN defined pass i_scl, i_sda, i_f_ref, i_f_ref_slow through 2-flop synchronizers; REQ-016 latency still <=3 cycles after sync output, <=4 from pin.
REQ-024 SHALL without I2C_PASSTHRU_IN_SYNC_EN use single sample registers; all other behaviour identical.

Structure
REQ-025 SHALL place default parameter values and counter widths in shared package i2c_passthru_pkg.
REQ-026 SHALL use one sub-module i2c_passthru_edge_det (sample register + rising/falling pulse), instantiated per input.

Verification
REQ-027 SHALL cover: reset, scl=sda=1 -> o_idle=1, o_stuck=0 within 700 us, stable for further 700 us.
REQ-028 SHALL cover: from idle, scl=sda=0 -> o_idle=0 within 4 clocks; sda=1 with scl=0 for 6 us -> o_idle=0, o_stuck=0 throughout.
REQ-029 SHALL cover: sda=0, scl=1, 2 clocks, sda=1 (STOP) -> o_idle=1 within 6 us, o_stuck=0.
REQ-030 SHALL cover: reset, scl=0, sda=1 -> both 0 for first 25 ms; o_stuck=1 before 200 ms (~32 ms); o_stuck=1, o_idle=0 held 25 ms more.
REQ-031 SHALL cover: reset, sda=0, scl=1 -> same timing as REQ-030.
REQ-032 SHALL cover: stuck then release lines high -> o_stuck=0 next clock, o_idle=1 within 700 us.
